// File: rtl/chrom_pio_pkg.sv
// Shared constants for the edge-capturing PIO input block:
// register word addresses and edge-detect mode encodings.
package chrom_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EVCOUNT  = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/chrom_pio_sync.sv
// Multi-stage flop synchroniser for the asynchronous PIO inputs.
// SYNC_STAGES = 0 degenerates to a plain wire.
module chrom_pio_sync #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset_n;
            assign q = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] stage_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        stage_reg[i] <= stage_reg[i-1];
                    end
                end
            end

            assign q = stage_reg[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/chrom_pio_in_edge.sv
// Avalon-MM PIO input port with edge capture, event counter and
// maskable level interrupt.
module chrom_pio_in_edge
    import chrom_pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] sync;
    logic [DATA_WIDTH-1:0] prev_reg;
    logic [DATA_WIDTH-1:0] edge_vec;
    logic [DATA_WIDTH-1:0] edge_cap_reg, edge_cap_next;
    logic [DATA_WIDTH-1:0] irq_mask_reg, irq_mask_next;
    logic [DATA_WIDTH-1:0] cap_clear;
    logic [31:0]           evcount_reg, evcount_next;
    logic [31:0]           read_mux;
    logic                  wr_en;

    chrom_pio_sync #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync)
    );

    generate
        if (EDGE_MODE == EDGE_RISING) begin : g_rise
            assign edge_vec = sync & ~prev_reg;
        end else if (EDGE_MODE == EDGE_FALLING) begin : g_fall
            assign edge_vec = ~sync & prev_reg;
        end else begin : g_any
            assign edge_vec = sync ^ prev_reg;
        end
    endgenerate

    assign wr_en = chipselect && !write_n;

    always_comb begin
        cap_clear = '0;
        if (wr_en && address == ADDR_EDGE_CAP) begin
            cap_clear = writedata[DATA_WIDTH-1:0];
        end
        // OR-ing the new edges in last makes a coincident set beat the clear
        edge_cap_next = (edge_cap_reg & ~cap_clear) | edge_vec;

        irq_mask_next = irq_mask_reg;
        if (wr_en && address == ADDR_IRQ_MASK) begin
            irq_mask_next = writedata[DATA_WIDTH-1:0];
        end

        // Clear first, then count, so a clear coinciding with an event yields 1
        evcount_next = evcount_reg;
        if (wr_en && address == ADDR_EVCOUNT) begin
            evcount_next = '0;
        end
        if (|edge_vec && evcount_next != '1) begin
            evcount_next = evcount_next + 32'd1;
        end
    end

    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:     read_mux = 32'(sync);
            ADDR_EVCOUNT:  read_mux = evcount_reg;
            ADDR_IRQ_MASK: read_mux = 32'(irq_mask_reg);
            ADDR_EDGE_CAP: read_mux = 32'(edge_cap_reg);
            default:       read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg     <= '0;
            edge_cap_reg <= '0;
            irq_mask_reg <= '0;
            evcount_reg  <= '0;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            prev_reg     <= sync;
            edge_cap_reg <= edge_cap_next;
            irq_mask_reg <= irq_mask_next;
            evcount_reg  <= evcount_next;
            readdata     <= read_mux;
            irq          <= |(edge_cap_next & irq_mask_next);
        end
    end

endmodule

// File: tb/tb_chrom_pio_in_edge.sv
// Three differently parametrised instances share one bus and input pins;
// a queue-based reference model predicts readdata and irq every cycle.
module tb_chrom_pio_in_edge;

    localparam int WID [3] = '{8, 5, 8};
    localparam int STG [3] = '{2, 1, 0};
    localparam int MOD [3] = '{0, 1, 2};

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [7:0]  in_port    = 8'd0;
    logic [31:0] rd_o  [3];
    logic        irq_o [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chrom_pio_in_edge #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_o[0]), .irq(irq_o[0])
    );

    chrom_pio_in_edge #(.DATA_WIDTH(5), .SYNC_STAGES(1), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port[4:0]),
        .readdata(rd_o[1]), .irq(irq_o[1])
    );

    chrom_pio_in_edge #(.DATA_WIDTH(8), .SYNC_STAGES(0), .EDGE_MODE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_o[2]), .irq(irq_o[2])
    );

    // Reference model: sync is simply the input seen STG edges ago.
    logic [7:0]  hist [$];
    logic [31:0] m_cap [3], m_mask [3], m_cnt [3], m_prev [3], exp_rd [3];
    logic        exp_irq [3];
    int          force_req  = 0;
    int          force_seen = 0;

    function automatic logic [31:0] wmask(int i);
        return (32'd1 << WID[i]) - 32'd1;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] s, e, wm;
        logic        wr;
        if (!reset_n) begin
            hist.delete();
            for (int i = 0; i < 3; i++) begin
                m_cap[i] = 0; m_mask[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
                exp_rd[i] = 0; exp_irq[i] = 1'b0;
            end
        end else begin
            if (force_req != force_seen) begin
                m_cnt[0]   = 32'hFFFF_FFFE;
                force_seen = force_req;
            end
            hist.push_front(in_port);
            if (hist.size() > 4) void'(hist.pop_back());
            wr = chipselect && !write_n;
            for (int i = 0; i < 3; i++) begin
                wm = wmask(i);
                s  = (hist.size() > STG[i]) ? {24'd0, hist[STG[i]]} & wm : 32'd0;
                case (MOD[i])
                    0:       e = s & ~m_prev[i];
                    1:       e = ~s & m_prev[i];
                    default: e = s ^ m_prev[i];
                endcase
                e = e & wm;
                case (address)
                    2'd0: exp_rd[i] = s;
                    2'd1: exp_rd[i] = m_cnt[i];
                    2'd2: exp_rd[i] = m_mask[i];
                    default: exp_rd[i] = m_cap[i];
                endcase
                if (wr && address == 2'd3) m_cap[i] = m_cap[i] & ~(writedata & wm);
                m_cap[i] = m_cap[i] | e;
                if (wr && address == 2'd1) m_cnt[i] = 0;
                if (e != 0 && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 1;
                if (wr && address == 2'd2) m_mask[i] = writedata & wm;
                exp_irq[i] = |(m_cap[i] & m_mask[i]);
                m_prev[i]  = s;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (reset_n) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_rd%0d", i), rd_o[i], exp_rd[i]);
                check($sformatf("model_irq%0d", i), {31'd0, irq_o[i]}, {31'd0, exp_irq[i]});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b0; write_n = 1'b1;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_rd%0d", tag, i), rd_o[i], 32'd0);
            check($sformatf("%s_irq%0d", tag, i), {31'd0, irq_o[i]}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        reset_n = 1'b1;

        // Quiet reset release: every register reads zero
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            check($sformatf("rst_reg%0d", a), rd_o[0], 32'd0);
            check("rst_irq", {31'd0, irq_o[0]}, 32'd0);
        end

        // Rising edges on bits 0 and 2
        in_port = 8'h05;
        idle(3);
        bus_read(2'd3); check("cap_rise", rd_o[0], 32'h05);
        bus_read(2'd1); check("cnt_rise", rd_o[0], 32'd1);
        bus_read(2'd0); check("data_05", rd_o[0], 32'h05);

        // Falling edges are invisible in rising mode
        in_port = 8'h00;
        idle(4);
        bus_read(2'd3); check("cap_fall", rd_o[0], 32'h05);
        bus_read(2'd1); check("cnt_fall", rd_o[0], 32'd1);

        bus_write(2'd2, 32'h04);
        check("irq_set", {31'd0, irq_o[0]}, 32'd1);
        bus_write(2'd3, 32'h04);
        check("irq_clr", {31'd0, irq_o[0]}, 32'd0);
        bus_read(2'd3); check("cap_w1c", rd_o[0], 32'h01);

        // Clear of bit 0 lands on the same edge that sets it
        in_port = 8'h01;
        idle(2);
        bus_write(2'd3, 32'h01);
        bus_read(2'd3); check("set_wins", rd_o[0], 32'h01);
        bus_read(2'd1); check("cnt_two", rd_o[0], 32'd2);

        // Saturation
        force dut0.evcount_reg = 32'hFFFF_FFFE;
        force_req++;
        #1;
        release dut0.evcount_reg;
        in_port = 8'h03; step();
        in_port = 8'h07; step();
        in_port = 8'h0F; step();
        idle(3);
        bus_read(2'd1); check("cnt_sat", rd_o[0], 32'hFFFF_FFFF);

        // Counter clear coincident with an event
        in_port = 8'h1F;
        idle(2);
        bus_write(2'd1, 32'd0);
        bus_read(2'd1); check("cnt_clr_evt", rd_o[0], 32'd1);

        // Asynchronous reset mid-operation
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        idle(2);
        reset_n = 1'b1;

        // Inputs already high at release appear as rising edges
        idle(3);
        bus_read(2'd3); check("rel_cap", rd_o[0], 32'h1F);
        bus_read(2'd1); check("rel_cnt", rd_o[0], 32'd1);

        // Unsynchronised any-edge instance: bit 3 captured on the next edge
        bus_write(2'd3, 32'hFF);
        in_port = 8'h17;
        step();
        bus_read(2'd3); check("any_bit3", rd_o[2], 32'h08);

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) begin
                reset_n = 1'b0;
                #1;
                check_all_zero("rnd_reset");
                step();
                reset_n = 1'b1;
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
